// File: rtl/quad_encoder_gen_pkg.sv
// ---------------------------------------------------------------------------
// quad_gen_pkg
// Shared definitions for the quadrature encoder generator:
//   state_e      - controller states (IDLE waiting for a command, RUN emitting)
//   PH_xx        - 2-bit {A,B} phase codes of the quadrature cycle
//   DIR_INC/DEC  - direction encoding of cmd_dir
//   next_phase() - one Gray step of the {A,B} pair in the given direction
// ---------------------------------------------------------------------------
package quad_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Incrementing walks 00->10->11->01->00 (A leads B); decrementing walks
    // the same ring backwards, so exactly one bit changes per step.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = (dir == DIR_INC) ? PH_10 : PH_01;
            PH_10:   nxt = (dir == DIR_INC) ? PH_11 : PH_00;
            PH_11:   nxt = (dir == DIR_INC) ? PH_01 : PH_10;
            default: nxt = (dir == DIR_INC) ? PH_00 : PH_11;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen_if
// Command channel of the quadrature generator.
//   cmd_valid  - command offered by the master
//   cmd_ready  - generator idle and able to take a command
//   cmd_dir    - 1 = increment (A leads B), 0 = decrement
//   cmd_steps  - number of A/B transitions to emit
//   cmd_period - clock cycles between transitions (0 behaves as 1)
//   cmd_abort  - stop the command in progress
// Modports: master drives the command, slave is the generator.
// ---------------------------------------------------------------------------
interface quad_encoder_gen_if #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [COUNT_W-1:0]  cmd_steps;
    logic [PERIOD_W-1:0] cmd_period;
    logic                cmd_abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
        output cmd_ready
    );

endinterface

// File: rtl/quad_encoder_gen_phase_seq.sv
// ---------------------------------------------------------------------------
// quad_phase_seq
// 2-bit Gray up/down register producing the quadrature phases.
//   clk, reset - system clock, asynchronous active-high reset (phase -> 00)
//   step_i     - advance one Gray step this cycle
//   dir_i      - step direction (DIR_INC / DIR_DEC)
//   enc_a_o    - phase A, straight from a flop
//   enc_b_o    - phase B, straight from a flop
// ---------------------------------------------------------------------------
module quad_phase_seq
    import quad_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step_i,
    input  logic dir_i,
    output logic enc_a_o,
    output logic enc_b_o
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (step_i) begin
            phase_d = next_phase(phase_q, dir_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_00;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign enc_a_o = phase_q[1];
    assign enc_b_o = phase_q[0];

endmodule

// File: rtl/quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen
// Quadrature encoder signal generator. Takes a command of N steps, direction
// and step period, emits Gray-coded A/B transitions at that rate, tracks the
// net position and pulses done on normal completion.
//   clk, reset   - system clock, asynchronous active-high reset
//   cmd          - command channel (slave modport of quad_encoder_gen_if)
//   enc_a, enc_b - quadrature outputs
//   busy         - command in progress
//   done         - one-cycle pulse when a command completes (not on abort)
//   pos          - wrapping two's complement net transition count
// ---------------------------------------------------------------------------
module quad_encoder_gen
    import quad_gen_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8,
    parameter int POS_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    quad_encoder_gen_if.slave     cmd,
    output logic                  enc_a,
    output logic                  enc_b,
    output logic                  busy,
    output logic                  done,
    output logic [POS_W-1:0]      pos
);

    state_e              state_q,  state_d;
    logic                dir_q,    dir_d;
    logic [COUNT_W-1:0]  steps_q,  steps_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q,  timer_d;
    logic [POS_W-1:0]    pos_q,    pos_d;
    logic                busy_q,   busy_d;
    logic                ready_q,  ready_d;
    logic                done_q,   done_d;
    logic                step;
    logic [PERIOD_W-1:0] period_eff;

    assign period_eff = (cmd.cmd_period == '0) ? PERIOD_W'(1) : cmd.cmd_period;

    // The timer is loaded with the period on acceptance and counts down;
    // reaching 1 marks a transition edge, so transition k lands exactly
    // k*P edges after the accepting edge. steps_q holds the transitions
    // still owed, and the one that sees steps_q==1 is the last.
    // Abort has priority over a coincident transition.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        steps_d  = steps_q;
        period_d = period_q;
        timer_d  = timer_q;
        pos_d    = pos_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    dir_d    = cmd.cmd_dir;
                    steps_d  = cmd.cmd_steps;
                    period_d = period_eff;
                    timer_d  = period_eff;
                    if (cmd.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end
            RUN: begin
                if (cmd.cmd_abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (timer_q == PERIOD_W'(1)) begin
                    step    = 1'b1;
                    timer_d = period_q;
                    pos_d   = (dir_q == DIR_INC) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    if (steps_q == COUNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        steps_d = steps_q - COUNT_W'(1);
                    end
                end else begin
                    timer_d = timer_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_q    <= DIR_INC;
            steps_q  <= '0;
            period_q <= '0;
            timer_q  <= '0;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    quad_phase_seq u_phase_seq (
        .clk     (clk),
        .reset   (reset),
        .step_i  (step),
        .dir_i   (dir_q),
        .enc_a_o (enc_a),
        .enc_b_o (enc_b)
    );

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pos           = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// tb_quad_encoder_gen
// Self-checking bench for quad_encoder_gen. The reference model keeps the
// quadrature phase as an index around the ring 00,10,11,01 and the position
// as a plain counter; a command of N steps at period P accepted at edge T
// is expected to show floor(t/P) steps at edge T+t.
// ---------------------------------------------------------------------------
module tb_quad_encoder_gen;
    import quad_gen_pkg::*;

    localparam int PERIOD_W = 16;
    localparam int COUNT_W  = 8;
    localparam int POS_W    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enc_a;
    logic             enc_b;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] pos;

    quad_encoder_gen_if #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) ifc ();

    quad_encoder_gen #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .POS_W(POS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (ifc.slave),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .busy  (busy),
        .done  (done),
        .pos   (pos)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // model: ring index of the phase and net position
    int               mIdx;
    logic [POS_W-1:0] mPos;

    // observed bundle {A,B,pos,busy,done,cmd_ready}
    wire [12:0] obs = {enc_a, enc_b, pos, busy, done, ifc.cmd_ready};

    function automatic logic [1:0] abOf(input int idx);
        case (((idx % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [12:0] expectOf(input int idx, input logic [POS_W-1:0] p,
                                             input logic b, input logic d, input logic r);
        return {abOf(idx), p, b, d, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startCmd(input logic dir, input int steps, input int period);
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_dir    = dir;
        ifc.cmd_steps  = COUNT_W'(steps);
        ifc.cmd_period = PERIOD_W'(period);
        tick();
        ifc.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mIdx = 0;
        mPos = '0;
        testsRun++;
        if (obs !== expectOf(0, '0, 1'b0, 1'b0, 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL reset_held got=%h exp=%h", obs, expectOf(0, '0, 1'b0, 1'b0, 1'b1));
        end
        reset = 1'b0;
        tick();
        testsRun++;
        if (obs !== expectOf(0, '0, 1'b0, 1'b0, 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL reset_release got=%h exp=%h", obs, expectOf(0, '0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_decrement_wrap();
        logic [12:0] exp [4];
        exp[0] = {2'b01, 8'hFF, 1'b1, 1'b0, 1'b0};
        exp[1] = {2'b11, 8'hFE, 1'b0, 1'b1, 1'b1};
        exp[2] = {2'b01, 8'hFF, 1'b1, 1'b0, 1'b0};
        exp[3] = {2'b00, 8'h00, 1'b0, 1'b1, 1'b1};
        startCmd(DIR_DEC, 2, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) startCmd(DIR_INC, 2, 1);
            tick();
            testsRun++;
            if (obs !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL dec_wrap step=%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_basic_increment();
        logic [12:0] e;
        startCmd(DIR_INC, 4, 3);
        for (int t = 1; t <= 13; t++) begin
            tick();
            e = (t <= 12) ? expectOf(mIdx + t / 3, mPos + POS_W'(t / 3), t < 12, t == 12, t == 12)
                          : expectOf(mIdx + 4, mPos + POS_W'(4), 1'b0, 1'b0, 1'b1);
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL basic_inc t=%0d got=%h exp=%h", t, obs, e);
            end
        end
        mIdx += 4;
        mPos += POS_W'(4);
    endtask

    task automatic test_degenerate();
        logic d;
        int   sgn;
        logic [12:0] e;
        startCmd(DIR_INC, 0, 3);
        testsRun++;
        if (obs !== expectOf(mIdx, mPos, 1'b0, 1'b1, 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL zero_steps_done got=%h exp=%h", obs, expectOf(mIdx, mPos, 1'b0, 1'b1, 1'b1));
        end
        tick();
        testsRun++;
        if (obs !== expectOf(mIdx, mPos, 1'b0, 1'b0, 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL zero_steps_after got=%h exp=%h", obs, expectOf(mIdx, mPos, 1'b0, 1'b0, 1'b1));
        end
        d   = 1'($urandom_range(0, 1));
        sgn = d ? 1 : -1;
        startCmd(d, 3, 0);
        for (int t = 1; t <= 3; t++) begin
            tick();
            e = expectOf(mIdx + sgn * t, mPos + POS_W'(sgn * t), t < 3, t == 3, t == 3);
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL period_zero t=%0d got=%h exp=%h", t, obs, e);
            end
        end
        mIdx += sgn * 3;
        mPos += POS_W'(sgn * 3);
    endtask

    task automatic test_back_to_back();
        logic        d [2];
        int          n [2];
        int          pe [2];
        int          sgn;
        logic [12:0] e;
        d[0] = 1'($urandom_range(0, 1));  n[0] = 2; pe[0] = 5;
        d[1] = 1'($urandom_range(0, 1));  n[1] = 3; pe[1] = 2;
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_dir    = d[0];
        ifc.cmd_steps  = COUNT_W'(n[0]);
        ifc.cmd_period = PERIOD_W'(pe[0]);
        tick();
        // second command held valid for the whole of the first one
        ifc.cmd_dir    = d[1];
        ifc.cmd_steps  = COUNT_W'(n[1]);
        ifc.cmd_period = PERIOD_W'(pe[1]);
        for (int c = 0; c < 2; c++) begin
            sgn = d[c] ? 1 : -1;
            for (int t = 1; t <= n[c] * pe[c]; t++) begin
                tick();
                e = expectOf(mIdx + sgn * (t / pe[c]), mPos + POS_W'(sgn * (t / pe[c])),
                             t < n[c] * pe[c], t == n[c] * pe[c], t == n[c] * pe[c]);
                testsRun++;
                if (obs !== e) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b cmd=%0d t=%0d got=%h exp=%h", c, t, obs, e);
                end
            end
            mIdx += sgn * n[c];
            mPos += POS_W'(sgn * n[c]);
            tick();
            e = (c == 0) ? expectOf(mIdx, mPos, 1'b1, 1'b0, 1'b0)
                         : expectOf(mIdx, mPos, 1'b0, 1'b0, 1'b1);
            ifc.cmd_valid = 1'b0;
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL b2b_after cmd=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_abort();
        logic        d;
        int          sgn;
        logic [12:0] e;
        d   = 1'($urandom_range(0, 1));
        sgn = d ? 1 : -1;
        startCmd(d, 10, 4);
        for (int t = 1; t <= 7; t++) begin
            tick();
            e = expectOf(mIdx + sgn * (t / 4), mPos + POS_W'(sgn * (t / 4)), 1'b1, 1'b0, 1'b0);
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL abort_run t=%0d got=%h exp=%h", t, obs, e);
            end
        end
        ifc.cmd_abort = 1'b1;
        tick();
        ifc.cmd_abort = 1'b0;
        mIdx += sgn;
        mPos += POS_W'(sgn);
        for (int t = 0; t < 6; t++) begin
            if (t > 0) tick();
            e = expectOf(mIdx, mPos, 1'b0, 1'b0, 1'b1);
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL abort_idle t=%0d got=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic test_abort_idle_accept();
        logic        d;
        int          sgn;
        logic [12:0] e;
        d   = 1'($urandom_range(0, 1));
        sgn = d ? 1 : -1;
        ifc.cmd_abort = 1'b1;
        startCmd(d, 1, 2);
        ifc.cmd_abort = 1'b0;
        for (int t = 0; t <= 2; t++) begin
            if (t > 0) tick();
            e = expectOf(mIdx + sgn * (t / 2), mPos + POS_W'(sgn * (t / 2)), t < 2, t == 2, t == 2);
            testsRun++;
            if (obs !== e) begin
                testsFailed++;
                $display("[TB] FAIL abort_accept t=%0d got=%h exp=%h", t, obs, e);
            end
        end
        mIdx += sgn;
        mPos += POS_W'(sgn);
    endtask

    task automatic test_random();
        logic        d;
        int          n, p, pe, sgn, gap;
        logic [12:0] e;
        for (int i = 0; i < 10; i++) begin
            d   = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 6);
            p   = $urandom_range(0, 4);
            pe  = (p == 0) ? 1 : p;
            sgn = d ? 1 : -1;
            gap = $urandom_range(0, 3);
            repeat (gap) tick();
            startCmd(d, n, p);
            for (int t = 1; t <= n * pe + 1; t++) begin
                tick();
                e = (t <= n * pe)
                    ? expectOf(mIdx + sgn * (t / pe), mPos + POS_W'(sgn * (t / pe)),
                               t < n * pe, t == n * pe, t == n * pe)
                    : expectOf(mIdx + sgn * n, mPos + POS_W'(sgn * n), 1'b0, 1'b0, 1'b1);
                testsRun++;
                if (obs !== e) begin
                    testsFailed++;
                    $display("[TB] FAIL random i=%0d n=%0d p=%0d t=%0d got=%h exp=%h", i, n, p, t, obs, e);
                end
            end
            mIdx += sgn * n;
            mPos += POS_W'(sgn * n);
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mIdx  = 0;
        mPos  = '0;
        tick();
        startCmd(DIR_INC, 10, 2);
        repeat (6) tick();
        testsRun++;
        if (obs !== {2'b01, 8'd3, 1'b1, 1'b0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL async_pre got=%h exp=%h", obs, {2'b01, 8'd3, 1'b1, 1'b0, 1'b0});
        end
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if (obs !== expectOf(0, '0, 1'b0, 1'b0, 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL async_reset got=%h exp=%h", obs, expectOf(0, '0, 1'b0, 1'b0, 1'b1));
        end
        @(negedge clk);
        reset = 1'b0;
        startCmd(DIR_DEC, 1, 1);
        tick();
        e = {2'b01, 8'hFF, 1'b0, 1'b1, 1'b1};
        testsRun++;
        if (obs !== e) begin
            testsFailed++;
            $display("[TB] FAIL async_resume got=%h exp=%h", obs, e);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_dir    = 1'b0;
        ifc.cmd_steps  = '0;
        ifc.cmd_period = '0;
        ifc.cmd_abort  = 1'b0;
        test_reset();
        test_decrement_wrap();
        test_basic_increment();
        test_degenerate();
        test_back_to_back();
        test_abort();
        test_abort_idle_accept();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
Quadrature encoder signal generator: the transmit end of the encoder A/B interface that rgb_mixer decodes on its enc*_a/enc*_b inputs.
- Accepts a command of N steps, a direction and a step period, and emits Gray-coded A/B transitions at the commanded rate.
- Tracks net position and reports completion.
- Used as an on-chip stimulus source for rgb_mixer bring-up (driven via logic analyzer bits), and directly in benches as the encoder model.

Parameters:
PERIOD_W, 16, width of step-period field (clock cycles between transitions)
COUNT_W, 8, width of step-count field
POS_W, 8, width of wrapping signed net-position counter

Ports:
clk  input  1  system clock (wb_clk_i at the top level)
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command can be accepted (high only in IDLE)
cmd_dir  input  1  1 = increment (A leads B), 0 = decrement (B leads A)
cmd_steps  input  COUNT_W  number of A/B transitions to emit
cmd_period  input  PERIOD_W  cycles between transitions; 0 treated as 1
cmd_abort  input  1  stop current command
enc_a  output  1  quadrature phase A
enc_b  output  1  quadrature phase B
busy  output  1  command in progress
done  output  1  one-cycle pulse on normal completion
pos  output  POS_W  net transitions emitted since reset, two's complement, wraps

Behaviour:
- Reset (async assert, sync-release assumed by top level):
  - {enc_a,enc_b}=00, pos=0, busy=0, done=0, cmd_ready=1, state IDLE, timers cleared.
  - Applies immediately, including mid-command.
- All outputs are registered; cmd_ready = (state==IDLE), registered.
- States:
  - IDLE: cmd_valid&&cmd_ready at edge T latches dir, steps and period (period 0 is stored as 1).
    - steps==0: stay IDLE; done=1 for the cycle after T; no edges.
    - steps>0: go to RUN; busy=1 and cmd_ready=0 from T.
  - RUN:
    - Timer counts latched-period cycles. Transition k (k=1..N) occurs at edge T+k*P.
    - Each transition advances phase one Gray step and updates pos by ±1 (wraps modulo 2^POS_W).
    - At edge T+N*P (final transition): return to IDLE; busy=0, cmd_ready=1 and done=1 for one cycle, all from that edge.
    - A new command may be accepted in the cycle done is high (back-to-back); its first transition then lands P_new cycles later.
- Phase sequence:
  - dir=1: AB 00→10→11→01→00.
  - dir=0: AB 00→01→11→10→00.
  - Phase is continuous across commands and is never reset by a new command.
- Exactly one of A/B changes per transition; no glitches, since both come straight from flops.
- cmd_valid while busy: ignored (not ready); cmd fields are not re-sampled.
- cmd_abort:
  - In RUN: go to IDLE at next edge; no further transitions; phase and pos held; done NOT pulsed.
  - Abort on the same edge as a scheduled transition: the transition is suppressed.
  - In IDLE: no effect.
  - Abort and cmd_valid in the same IDLE cycle: the command is accepted.
- Widths:
  - Step counter is COUNT_W; period timer is PERIOD_W.
  - Max command = (2^COUNT_W−1) steps at (2^PERIOD_W−1) cycles each.

Decomposition:
- Package quad_gen_pkg:
  - State enum {IDLE, RUN}.
  - 2-bit phase constants PH_00, PH_10, PH_11, PH_01.
  - DIR_INC/DIR_DEC.
- Sub-module quad_phase_seq: 2-bit Gray up/down register with step and dir inputs; outputs enc_a/enc_b; async reset to 00.
- Timer, step counter, FSM and pos counter stay in quad_encoder_gen.

Test Plan:
- Basic increment:
  - From reset, cmd steps=4 dir=1 period=3 accepted at edge T.
  - AB=10@T+3, 11@T+6, 01@T+9, 00@T+12.
  - done high one cycle after T+12; pos=4; busy low after T+12.
- Decrement with wrap:
  - From pos=0, AB=00: cmd steps=2 dir=0 period=1.
  - AB=01 then 11 on consecutive edges; pos=8'hFE.
  - Then cmd steps=2 dir=1 period=1 returns AB=00, pos=0.
- Zero and degenerate:
  - steps=0 → done pulse next cycle, AB unchanged, pos unchanged.
  - steps=3 period=0 → identical timing to period=1.
- Back-to-back and busy:
  - Second cmd held valid throughout first cmd (steps=2 period=5): ignored until done.
  - Accepted in the done cycle; its first edge lands exactly P_new later.
  - Phase continues from where the first cmd ended.
- Abort:
  - cmd steps=10 period=4; cmd_abort on cycle T+8 (coincident with 2nd transition).
  - Only 1 transition emitted; pos=1; no done; cmd_ready=1 next cycle.
- Async reset mid-command:
  - Assert reset between clock edges during RUN (pos=3, AB=01).
  - AB=00, pos=0, busy=0 and cmd_ready=1 immediately, without a clock edge.
  - Normal operation resumes after release.
